nios_debug_cmd_bridge: RTL and testbench

Parametrised successor to the debug-slave system-clock decoder. Takes the JTAG-side update strobes (vs_uir, vs_udr), the instruction register and the data shift register, which all arrive from the tck domain. Synchronises the strobes into clk and queues each update as a command in a small FIFO. On a handshake pop it emits per-instruction take_action / take_no_action pulses. Compared with the fixed 2-bit-IR, 38-bit, unbuffered predecessor, it adds generic IR/SR width, configurable synchroniser depth, command buffering with back-pressure, and overflow detection.

---
 rtl/nios_debug_cmd_bridge.sv | 117 +++++++++++
 tb/tb_nios_debug_cmd_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_debug_cmd_bridge.sv
// JTAG update-strobe to system-clock command bridge: synchronises vs_uir/vs_udr,
// queues each update-DR as an {ir, sr} command and decodes action pulses on pop.
module nios_debug_cmd_bridge #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int ACT_BIT     = 34,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  localparam int NUM_CH     = 2**IR_W,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [SR_W-1:0]   sr,
  input  logic              cmd_ready,
  input  logic              clr_ovf,
  output logic              cmd_valid,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [SR_W-1:0]   jdo,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
  logic                   uir_dly, udr_dly;
  logic                   uir_rise, udr_rise;
  logic [IR_W-1:0]        ir_reg;
  logic [IR_W-1:0]        mem_ir [DEPTH];
  logic [SR_W-1:0]        mem_sr [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [IR_W-1:0]        last_ir, head_ir;
  logic [SR_W-1:0]        last_sr, head_sr;
  logic                   full, pop, push_ok, ovf_set;

  function automatic logic [NUM_CH-1:0] decode(input logic [IR_W-1:0] ir, input logic en);
    logic [NUM_CH-1:0] v;
    v     = '0;
    v[ir] = en;
    return v;
  endfunction

  // Synchroniser chains plus edge-detect delay flops
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_dly  <= 1'b0;
      udr_dly  <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_dly  <= uir_sync[SYNC_STAGES-1];
      udr_dly  <= udr_sync[SYNC_STAGES-1];
    end
  end

  assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_dly;
  assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_dly;

  assign cmd_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push_ok   = udr_rise & (~full | pop);
  assign ovf_set   = udr_rise & full & ~pop;

  assign head_ir = mem_ir[rd_ptr];
  assign head_sr = mem_sr[rd_ptr];
  assign cmd_ir  = cmd_valid ? head_ir : last_ir;
  assign jdo     = cmd_valid ? head_sr : last_sr;

  // FIFO storage; ir_reg is read before any same-edge update-IR
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_ir[wr_ptr] <= ir_reg;
      mem_sr[wr_ptr] <= sr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_reg         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      last_ir        <= '0;
      last_sr        <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      if (uir_rise) ir_reg <= ir_in;
      if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        last_ir <= head_ir;
        last_sr <= head_sr;
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      take_action    <= decode(head_ir, pop &  head_sr[ACT_BIT]);
      take_no_action <= decode(head_ir, pop & ~head_sr[ACT_BIT]);
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_nios_debug_cmd_bridge.sv
// Bench for nios_debug_cmd_bridge: vector table plus scoreboard of queued commands.
module tb_nios_debug_cmd_bridge;

  localparam int SR_W = 38;
  localparam int IR_W = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            vs_uir = 1'b0, vs_udr = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            cmd_ready = 1'b0, clr_ovf = 1'b0;
  logic            cmd_valid;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] jdo;
  logic [3:0]      take_action, take_no_action;
  logic [2:0]      fifo_count;
  logic            overflow;

  nios_debug_cmd_bridge #(.SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(34), .SYNC_STAGES(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .cmd_ready(cmd_ready), .clr_ovf(clr_ovf), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IR_W-1:0] ir; logic [SR_W-1:0] sr; } entry_t;
  typedef struct { logic [IR_W-1:0] ir; logic [SR_W-1:0] sr; logic [3:0] act; logic [3:0] noact; } vec_t;

  entry_t          sb[$];
  vec_t            tbl[4];
  int              n_checks = 0;
  int              n_err = 0;
  logic [IR_W-1:0] mdl_ir = '0;
  logic            exp_ovf = 1'b0;
  logic [3:0]      exp_act = '0, exp_noact = '0;
  bit              mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse checks and scoreboard pops, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("take_action", take_action, exp_act);
      chk("take_no_action", take_no_action, exp_noact);
      exp_act   = '0;
      exp_noact = '0;
      if (!reset && cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          entry_t e;
          e = sb.pop_front();
          chk("head_ir", cmd_ir, e.ir);
          chk("head_jdo", jdo, e.sr);
          exp_act[e.ir]   = e.sr[34];
          exp_noact[e.ir] = ~e.sr[34];
        end
      end
    end
  end

  task automatic strobe(input bit do_uir, input bit do_udr, input logic [IR_W-1:0] irv,
                        input logic [SR_W-1:0] srv, input bit pop_at_push, input bit chk_lat);
    @(posedge clk); #1;
    if (do_uir) begin ir_in = irv; vs_uir = 1'b1; end
    if (do_udr) begin sr = srv; vs_udr = 1'b1; end
    @(posedge clk);
    @(posedge clk); #1;
    if (pop_at_push) cmd_ready = 1'b1;
    @(negedge clk); #1;
    if (chk_lat) chk("latency_before", cmd_valid, 0);
    if (do_udr) begin
      if (sb.size() < DEPTH) sb.push_back('{mdl_ir, srv});
      else exp_ovf = 1'b1;
    end
    if (do_uir) mdl_ir = irv;
    @(posedge clk); #1;
    if (pop_at_push) cmd_ready = 1'b0;
    @(negedge clk);
    if (chk_lat) chk("latency_after", cmd_valid, 1);
    @(posedge clk); #1;
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    repeat (DEPTH + 3) @(posedge clk);
    #1 cmd_ready = 1'b0;
    @(negedge clk);
    chk("drained_valid", cmd_valid, 0);
    chk("drained_count", fifo_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{2'd2, 38'h04_0000_0123, 4'b0100, 4'b0000};
    tbl[1] = '{2'd0, 38'h00_0000_0456, 4'b0000, 4'b0001};
    tbl[2] = '{2'd3, 38'h3F_FFFF_FFFF, 4'b1000, 4'b0000};
    tbl[3] = '{2'd1, 38'h3B_FFFF_FFFF, 4'b0000, 4'b0010};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cmd_ir", cmd_ir, 0);
    chk("rst_jdo", jdo, 0);
    chk("rst_take_action", take_action, 0);
    chk("rst_take_no_action", take_no_action, 0);
    mon_en = 1'b1;

    // Single commands: update-IR, update-DR, then one pop
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1, 1'b0, tbl[i].ir, '0, 1'b0, 1'b0);
      strobe(1'b0, 1'b1, '0, tbl[i].sr, 1'b0, 1'b1);
      @(negedge clk);
      chk("vec_count1", fifo_count, 1);
      chk("vec_cmd_ir", cmd_ir, tbl[i].ir);
      chk("vec_jdo", jdo, tbl[i].sr);
      @(posedge clk); #1 cmd_ready = 1'b1;
      @(posedge clk); #1 cmd_ready = 1'b0;
      @(negedge clk);
      chk("vec_take_action", take_action, tbl[i].act);
      chk("vec_take_no_action", take_no_action, tbl[i].noact);
      @(negedge clk);
      chk("vec_pulse_gone", take_action | take_no_action, 0);
      chk("vec_count0", fifo_count, 0);
    end

    // Overflow: five pushes into four slots
    for (int i = 1; i <= 5; i++) strobe(1'b0, 1'b1, '0, SR_W'(i), 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_model", exp_ovf, 1);
    drain();
    chk("ovf_last_jdo", jdo, 4);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with a push coinciding with a pop
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1, '0, SR_W'(16 + i), 1'b0, 1'b0);
    strobe(1'b0, 1'b1, '0, SR_W'(20), 1'b1, 1'b0);
    @(negedge clk);
    chk("fullpop_count", fifo_count, 4);
    chk("fullpop_overflow", overflow, 0);
    drain();
    chk("fullpop_last_jdo", jdo, 20);

    // Same-cycle update-IR and update-DR push the previous IR
    strobe(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0);
    strobe(1'b1, 1'b1, 2'd3, SR_W'(85), 1'b0, 1'b0);
    @(negedge clk);
    chk("same_cycle_ir", cmd_ir, 1);
    strobe(1'b0, 1'b1, '0, SR_W'(102), 1'b0, 1'b0);
    drain();
    chk("next_push_ir", cmd_ir, 3);

    // Reset with two entries queued and vs_udr held high through release
    strobe(1'b0, 1'b1, '0, SR_W'(119), 1'b0, 1'b0);
    strobe(1'b0, 1'b1, '0, SR_W'(136), 1'b0, 1'b0);
    @(posedge clk); #1;
    sr = SR_W'(153);
    vs_udr = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    mdl_ir = '0;
    exp_ovf = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_overflow", overflow, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    sb.push_back('{mdl_ir, SR_W'(153)});
    repeat (6) @(posedge clk);
    #1 vs_udr = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("post_rst_count", fifo_count, 1);
    chk("post_rst_jdo", jdo, 153);
    chk("post_rst_ir", cmd_ir, 0);
    drain();
    chk("sb_empty", sb.size(), 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
